// File: rtl/ext_input_wait_sched_pkg.sv
// Shared types for the external-input wait scheduler: slot state encoding and wait modes.
package ext_input_wait_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIT   = 2'd2
    } slot_state_e;

    localparam logic MODE_CHANGE = 1'b0;
    localparam logic MODE_EQUAL  = 1'b1;

endpackage

// File: rtl/ext_input_wait_sched_if.sv
// Request/ack bus between waiting threads (master) and the wait scheduler (slave).
// ack_timeout is present only when EXT_INPUT_WAIT_TIMEOUT_EN is defined.
interface ext_input_wait_sched_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_WAITERS  = 4
);
    localparam int unsigned ID_W = (N_WAITERS > 1) ? $clog2(N_WAITERS) : 1;

    logic [N_WAITERS-1:0]            req_valid;
    logic [N_WAITERS-1:0]            req_mode;
    logic [N_WAITERS*DATA_WIDTH-1:0] req_target;
    logic [N_WAITERS-1:0]            req_ready;
    logic                            ack_valid;
    logic [ID_W-1:0]                 ack_id;
    logic [DATA_WIDTH-1:0]           ack_data;
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
    logic                            ack_timeout;
`endif

    modport master (
        output req_valid, req_mode, req_target,
        input  req_ready, ack_valid, ack_id, ack_data
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
        , input ack_timeout
`endif
    );

    modport slave (
        input  req_valid, req_mode, req_target,
        output req_ready, ack_valid, ack_id, ack_data
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
        , output ack_timeout
`endif
    );

endinterface

// File: rtl/ext_input_wait_slot.sv
// One waiter slot: arms on request, watches the registered input, holds the hit until granted.
// Optional timeout counter under EXT_INPUT_WAIT_TIMEOUT_EN.
module ext_input_wait_slot
    import ext_input_wait_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_q,
    input  logic                  req_valid,
    input  logic                  req_mode,
    input  logic [DATA_WIDTH-1:0] req_target,
    input  logic                  grant,
    output logic                  ready,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] hit_data
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
    , output logic                timeout
`endif
);

    slot_state_e           state_q, state_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] target_q, target_d;
    logic [DATA_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0] hit_data_d;
    logic                  cond_c;

`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_d;
`endif

    assign cond_c = (mode_q == MODE_EQUAL) ? (i_q == target_q) : (i_q != base_q);

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        target_d   = target_q;
        base_d     = base_q;
        hit_data_d = hit_data;
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = timeout;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d  = ARMED;
                    mode_d   = req_mode;
                    target_d = req_target;
                    base_d   = i_q;
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
                    cnt_d     = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            ARMED: begin
                // A genuine hit takes priority over an expiring timeout
                if (cond_c) begin
                    state_d    = HIT;
                    hit_data_d = i_q;
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
                    timeout_d  = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = HIT;
                    hit_data_d = i_q;
                    timeout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            HIT: begin
                if (grant) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= MODE_CHANGE;
            target_q <= '0;
            base_q   <= '0;
            hit_data <= '0;
            ready    <= 1'b1;
            hit      <= 1'b0;
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
            cnt_q    <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            base_q   <= base_d;
            hit_data <= hit_data_d;
            ready    <= (state_d == IDLE);
            hit      <= (state_d == HIT);
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
            cnt_q    <= cnt_d;
            timeout  <= timeout_d;
`endif
        end
    end

endmodule

// File: rtl/ext_input_wait_sched.sv
// Shares a registered external input among N waiter slots and returns completions
// one per cycle through a round-robin arbiter. Timeout support: EXT_INPUT_WAIT_TIMEOUT_EN.
module ext_input_wait_sched
    import ext_input_wait_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned N_WAITERS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  i,
    ext_input_wait_sched_if.slave  bus
);

    localparam int unsigned ID_W = (N_WAITERS > 1) ? $clog2(N_WAITERS) : 1;

    if (N_WAITERS < 2 || N_WAITERS > 8) begin : g_bad_n_waiters
        $error("N_WAITERS must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [DATA_WIDTH-1:0] i_q;
    logic [N_WAITERS-1:0]  ready_vec;
    logic [N_WAITERS-1:0]  hit_vec;
    logic [N_WAITERS-1:0]  grant_c;
    logic [DATA_WIDTH-1:0] hit_data_arr [N_WAITERS];
    logic [ID_W-1:0]       rr_q;
    logic [ID_W-1:0]       winner_c;
    logic                  any_c;
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
    logic [N_WAITERS-1:0]  to_vec;
`endif

    for (genvar k = 0; k < N_WAITERS; k++) begin : g_slot
        ext_input_wait_slot #(
            .DATA_WIDTH     (DATA_WIDTH)
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
            , .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .i_q        (i_q),
            .req_valid  (bus.req_valid[k]),
            .req_mode   (bus.req_mode[k]),
            .req_target (bus.req_target[k*DATA_WIDTH +: DATA_WIDTH]),
            .grant      (grant_c[k]),
            .ready      (ready_vec[k]),
            .hit        (hit_vec[k]),
            .hit_data   (hit_data_arr[k])
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
            , .timeout  (to_vec[k])
`endif
        );
    end

    assign bus.req_ready = ready_vec;

    // Round-robin pick: first hit slot at or after rr, cyclically
    always_comb begin
        int unsigned idx;
        idx      = 0;
        winner_c = '0;
        any_c    = 1'b0;
        for (int unsigned j = 0; j < N_WAITERS; j++) begin
            idx = (32'(rr_q) + j) % N_WAITERS;
            if (!any_c && hit_vec[ID_W'(idx)]) begin
                any_c    = 1'b1;
                winner_c = ID_W'(idx);
            end
        end
    end

    assign grant_c = any_c ? (N_WAITERS'(1) << winner_c) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q           <= '0;
            rr_q          <= '0;
            bus.ack_valid <= 1'b0;
            bus.ack_id    <= '0;
            bus.ack_data  <= '0;
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
            bus.ack_timeout <= 1'b0;
`endif
        end else begin
            i_q           <= i;
            bus.ack_valid <= any_c;
            if (any_c) begin
                bus.ack_id   <= winner_c;
                bus.ack_data <= hit_data_arr[winner_c];
                rr_q         <= (winner_c == ID_W'(N_WAITERS - 1)) ? '0 : winner_c + ID_W'(1);
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
                bus.ack_timeout <= to_vec[winner_c];
`endif
            end
        end
    end

endmodule

// File: tb/tb_ext_input_wait_sched.sv
// Randomized and directed bench for ext_input_wait_sched against a cycle-level behavioural model.
module tb_ext_input_wait_sched;

    localparam int unsigned DW = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned TO = 16;
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] i_drv = '0;

    ext_input_wait_sched_if #(.DATA_WIDTH(DW), .N_WAITERS(N)) bus ();

    ext_input_wait_sched #(
        .DATA_WIDTH     (DW),
        .N_WAITERS      (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .i   (i_drv),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int acks_seen = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: each waiter is "busy" from accept until its ack, "done" once its
    // condition (or timeout) has been observed on the sampled input.
    bit            m_busy [N];
    bit            m_done [N];
    bit            m_mode [N];
    logic [DW-1:0] m_tgt  [N];
    logic [DW-1:0] m_base [N];
    logic [DW-1:0] m_val  [N];
    bit            m_to   [N];
    int            m_age  [N];
    int            m_rr;
    logic [DW-1:0] m_iq;
    bit            e_valid;
    int            e_id;
    logic [DW-1:0] e_data;
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
    bit            e_to;
`endif

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_busy[k] = 0; m_done[k] = 0; m_mode[k] = 0; m_tgt[k] = '0;
            m_base[k] = '0; m_val[k] = '0; m_to[k] = 0; m_age[k] = 0;
        end
        m_rr = 0; m_iq = '0; e_valid = 0; e_id = 0; e_data = '0;
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
        e_to = 0;
`endif
    endtask

    task automatic model_step(input logic [DW-1:0] iv, input logic [N-1:0] v,
                              input logic [N-1:0] md, input logic [N*DW-1:0] tg);
        int win;
        bit met;
        win = -1;
        for (int j = 0; j < N; j++) begin
            int k;
            k = (m_rr + j) % N;
            if (win < 0 && m_done[k]) win = k;
        end
        e_valid = (win >= 0);
        if (win >= 0) begin
            e_id   = win;
            e_data = m_val[win];
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
            e_to   = m_to[win];
`endif
            m_rr   = (win + 1) % N;
        end
        for (int k = 0; k < N; k++) begin
            if (!m_busy[k]) begin
                if (v[k]) begin
                    m_busy[k] = 1; m_done[k] = 0; m_mode[k] = md[k];
                    m_tgt[k]  = tg[k*DW +: DW]; m_base[k] = m_iq; m_age[k] = 0; m_to[k] = 0;
                end
            end else if (m_done[k]) begin
                if (k == win) begin
                    m_busy[k] = 0; m_done[k] = 0;
                end
            end else begin
                met = m_mode[k] ? (m_iq == m_tgt[k]) : (m_iq != m_base[k]);
                if (met) begin
                    m_done[k] = 1; m_val[k] = m_iq; m_to[k] = 0;
                end else if (TO_EN && m_age[k] == TO - 1) begin
                    m_done[k] = 1; m_val[k] = m_iq; m_to[k] = 1;
                end else begin
                    m_age[k]++;
                end
            end
        end
        m_iq = iv;
    endtask

    task automatic compare_outputs();
        logic [N-1:0] exp_ready;
        for (int k = 0; k < N; k++) exp_ready[k] = !m_busy[k];
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        check("ack_valid", 64'(bus.ack_valid), 64'(e_valid));
        check("ack_id",    64'(bus.ack_id),    64'(e_id));
        check("ack_data",  64'(bus.ack_data),  64'(e_data));
`ifdef EXT_INPUT_WAIT_TIMEOUT_EN
        check("ack_timeout", 64'(bus.ack_timeout), 64'(e_to));
`endif
        if (bus.ack_valid === 1'b1) acks_seen++;
    endtask

    // One clock: check outputs at negedge, drive new inputs, advance model at posedge
    task automatic tick(input logic [DW-1:0] iv, input logic [N-1:0] v,
                        input logic [N-1:0] md, input logic [N*DW-1:0] tg);
        @(negedge clk);
        compare_outputs();
        i_drv          = iv;
        bus.req_valid  = v;
        bus.req_mode   = md;
        bus.req_target = tg;
        @(posedge clk);
        model_step(iv, v, md, tg);
    endtask

    task automatic idle(input logic [DW-1:0] iv, input int n);
        for (int c = 0; c < n; c++) tick(iv, '0, '0, '0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        bus.req_valid = '0;
        #5 rst = 1'b1;
        model_reset();
        #30 rst = 1'b0;
    endtask

    function automatic logic [N*DW-1:0] tg_all(input logic [DW-1:0] t);
        return {N{t}};
    endfunction

    initial begin
        int base_acks;
        logic [DW-1:0]   iv;
        logic [N-1:0]    v, md;
        logic [N*DW-1:0] tg;

        bus.req_valid  = '0;
        bus.req_mode   = '0;
        bus.req_target = '0;
        model_reset();
        #105 rst = 1'b0;
        @(posedge clk);
        model_step('0, '0, '0, '0);

        // Single any-change waiter; exactly one ack over a long quiet window
        base_acks = acks_seen;
        tick('0, 4'b0001, 4'b0000, '0);
        idle('0, 3);
        idle(DW'(123), 500);
        check("single_change_ack_count", 64'(acks_seen - base_acks), 64'd1);

        // Three equal-target waiters complete on consecutive cycles
        idle('0, 2);
        tick('0, 4'b0111, 4'b0111, tg_all(DW'(123)));
        idle('0, 2);
        base_acks = acks_seen;
        idle(DW'(123), 8);
        check("three_equal_ack_count", 64'(acks_seen - base_acks), 64'd3);

        // Target already present at accept
        idle(DW'(5), 2);
        tick(DW'(5), 4'b0100, 4'b0100, tg_all(DW'(5)));
        idle(DW'(5), 4);

        // Round-robin: grant slot 1, then 0 and 3 hit together
        idle(DW'(9), 2);
        tick(DW'(9), 4'b0010, 4'b0010, tg_all(DW'(9)));
        idle(DW'(9), 4);
        idle('0, 2);
        tick('0, 4'b1001, 4'b1001, tg_all(DW'(44)));
        idle('0, 2);
        idle(DW'(44), 6);

        // Reset while armed drops the wait; re-arm afterwards
        tick('0, 4'b0010, 4'b0000, '0);
        idle('0, 2);
        base_acks = acks_seen;
        reset_pulse();
        idle('0, 3);
        check("reset_drops_ack", 64'(acks_seen - base_acks), 64'd0);
        tick('0, 4'b0010, 4'b0000, '0);
        idle('0, 2);
        idle(DW'(77), 5);

        // Held input with unreachable target: timeout or indefinite wait
        idle(DW'(7), 2);
        tick(DW'(7), 4'b0001, 4'b0001, tg_all(DW'(99)));
        base_acks = acks_seen;
        idle(DW'(7), 500);
        check("held_input_ack_count", 64'(acks_seen - base_acks), TO_EN ? 64'd1 : 64'd0);
        reset_pulse();

        // Randomized traffic on a small value alphabet so equality hits occur
        iv = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) iv = DW'($urandom_range(0, 3));
            v  = N'($urandom & $urandom);
            md = N'($urandom);
            for (int k = 0; k < N; k++) tg[k*DW +: DW] = DW'($urandom_range(0, 3));
            tick(iv, v, md, tg);
        end
        idle(iv, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ext_input_wait_sched.md
Name: ext_input_wait_sched

Overview:
- Shares one registered external input `i` among N waiting threads of a synthesized design.
- Each waiter arms a slot with a wait condition: "any change" or "equals target".
- The block monitors `i`, detects satisfied conditions, and returns completions one per cycle on a shared round-robin ack bus.
- Sits between the top-level `i` pin and the per-thread wait states of the generated main module.

Parameters:
- DATA_WIDTH, 32, width of `i` and of all data paths.
- N_WAITERS, 4, number of waiter slots (2..8).
- TIMEOUT_CYCLES, 1000, armed cycles before forced completion (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i  in  DATA_WIDTH  external input being waited on.
- req_valid  in  N_WAITERS  per-slot arm request.
- req_mode  in  N_WAITERS  per-slot mode: 0 = any change, 1 = equal to target.
- req_target  in  N_WAITERS*DATA_WIDTH  per-slot target; slot k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  N_WAITERS  slot k is idle and can accept a request.
- ack_valid  out  1  one-cycle completion pulse.
- ack_id  out  clog2(N_WAITERS)  index of the completed slot.
- ack_data  out  DATA_WIDTH  value of `i` at the moment the condition held.
- ack_timeout  out  1  completion was caused by timeout (exists only with the macro).

Behaviour:
- Input register: `i_q <= i` every cycle. All detection uses `i_q` only.
- Reset values (asynchronous): `i_q`=0, all slots IDLE, rr=0, ack_valid=0, ack_id=0, ack_data=0, ack_timeout=0.
- Reset mid-wait drops all armed and hit slots with no ack.
- Slot FSM states:
  - IDLE: req_ready[k]=1. On req_valid[k], latch mode and target, set base=i_q, go to ARMED. While a slot is not IDLE, req_valid[k] is ignored (no queuing).
  - ARMED: evaluated every cycle starting the cycle after accept. Mode 0 hits when i_q != base. Mode 1 hits when i_q == target. On hit, latch hit_data=i_q and go to HIT.
  - HIT: wait for grant. Once granted, go to IDLE.
- Mode 1 with i_q already equal to target at accept hits on the first ARMED cycle.
- Mode 0 only sees sampled values; a glitch shorter than one clock is not required to be seen.
- Arbitration:
  - Each cycle, among slots in HIT, grant the first index at or after rr, searching cyclically.
  - Registered result: ack_valid=1, ack_id=winner, ack_data=hit_data[winner]. Then rr <= (winner+1) mod N_WAITERS.
  - If no slot is in HIT, ack_valid=0 and ack_id/ack_data hold their previous values.
- ack_valid is a pulse with no backpressure. Exactly one ack per armed wait.
- Latency: `i` changes before edge E0 → i_q updates at E0 → slot enters HIT at E1 → ack_valid high after E2, assuming the grant is uncontended → slot IDLE after E2 → earliest re-arm accepted at E3.
- Simultaneous hits: one grant per cycle. Losing slots keep their latched hit_data, even if `i` changes again meanwhile.
- Accept and hit never occur in the same cycle for one slot.

Optional Feature:
- Macro: EXT_INPUT_WAIT_TIMEOUT_EN.
- With the macro:
  - Each slot has a counter, cleared on accept and incremented in ARMED.
  - When the counter reaches TIMEOUT_CYCLES-1 without a hit, the slot enters HIT with hit_data=i_q and its timeout flag set.
  - A real hit in the same cycle wins, and the flag stays 0.
  - ack_timeout mirrors the winner's flag; it resets to 0.
- Without the macro: no counters, no ack_timeout port, and a slot stays ARMED indefinitely.

Decomposition:
- Package ext_input_wait_pkg holds:
  - slot state enum (IDLE=0, ARMED=1, HIT=2);
  - mode constants (MODE_CHANGE=0, MODE_EQUAL=1).
- One sub-module, ext_input_wait_slot, instantiated N_WAITERS times.
  - It contains the FSM, base/target/hit_data registers and the optional timeout counter.
  - The top level holds `i_q`, the round-robin arbiter and the ack registers.

Test Plan:
- Setup for all tests: clock period 20 ns; rst high until 105 ns.
- Slot 0 arms mode 0 with i=0; at 210 ns i=123 → exactly one ack with ack_id=0, ack_data=123, two cycles after i_q updates; no further acks over 10000 ns.
- Slots 0, 1 and 2 arm mode 1 with target=123; i=123 → acks with ack_id 0, 1, 2 on three consecutive cycles, each ack_data=123; req_ready returns to 1 for each in turn.
- Slot 2 arms mode 1 with target=5 while i=5 → ack_id=2, ack_data=5 on the second cycle after accept.
- Round-robin check: grant slot 1 so rr=2; then slots 0 and 3 hit in the same cycle → ack_id 3 first, then 0.
- Slot 1 armed; rst pulses for 30 ns → no ack; req_ready=4'b1111 after release; a re-arm works normally.
- TIMEOUT_CYCLES=16 with i held at 7:
  - with EXT_INPUT_WAIT_TIMEOUT_EN → ack with ack_timeout=1 and ack_data=7, 16 cycles after accept (plus ack latency);
  - without the macro → no ack within 10000 ns.
